// File: rtl/mcdt_fmt_pkg.sv
// Shared types and helpers for the mcdt packet formatter.
// Header layout: magic, channel id and payload length in one 32-bit word.
package mcdt_fmt_pkg;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam int         NUM_CH    = 3;
  localparam int         ID_W      = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } fmt_state_e;

  function automatic logic [31:0] make_hdr(input logic [ID_W-1:0] id, input logic [7:0] len);
    return {HDR_MAGIC, 6'b0, id, 8'h00, len};
  endfunction

endpackage

// File: rtl/mcdt_fmt_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// Storage is not reset; only pointers and count are.
module mcdt_fmt_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mcdt_pkt_fmt.sv
// Buffers the mcdt word stream per channel and emits header+payload packets
// on a valid/ready port, arbitrating ready channels round-robin.
module mcdt_pkt_fmt
  import mcdt_fmt_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int PKT_LEN    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      mcdt_data_i,
  input  logic             mcdt_val_i,
  input  logic [ID_W-1:0]  mcdt_id_i,
  output logic [31:0]      fmt_data_o,
  output logic             fmt_valid_o,
  input  logic             fmt_ready_i,
  output logic             fmt_start_o,
  output logic             fmt_end_o,
  output logic [ID_W-1:0]  fmt_id_o,
  output logic [NUM_CH-1:0] ovf_o,
  output logic             err_id_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fmt_state_e        state, state_nxt;
  logic [NUM_CH-1:0] push, pop, full, empty, elig;
  logic [31:0]       head [NUM_CH];
  logic [CW-1:0]     cnt  [NUM_CH];
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   cand;
  logic              grant_vld;
  logic [7:0]        beat;
  logic              last_beat;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign push[g] = mcdt_val_i && (mcdt_id_i == ID_W'(g));
    assign pop[g]  = (state == BODY) && fmt_ready_i && (fmt_id_o == ID_W'(g)) && !empty[g];
    assign elig[g] = (cnt[g] >= CW'(PKT_LEN));

    mcdt_fmt_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (push[g]),
      .din   (mcdt_data_i),
      .pop   (pop[g]),
      .dout  (head[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .count (cnt[g])
    );
  end

  // First eligible channel scanning upward from the round-robin pointer.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_CH);
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign last_beat = (beat == 8'(PKT_LEN - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld)                state_nxt = HEAD;
      HEAD:    if (fmt_ready_i)              state_nxt = BODY;
      BODY:    if (fmt_ready_i && last_beat) state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fmt_valid_o = 1'b0;
    fmt_start_o = 1'b0;
    fmt_end_o   = 1'b0;
    fmt_data_o  = '0;
    case (state)
      HEAD: begin
        fmt_valid_o = 1'b1;
        fmt_start_o = 1'b1;
        fmt_data_o  = make_hdr(fmt_id_o, 8'(PKT_LEN));
      end
      BODY: begin
        fmt_valid_o = 1'b1;
        fmt_end_o   = last_beat;
        fmt_data_o  = head[fmt_id_o];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fmt_id_o <= '0;
      rr_ptr   <= '0;
      beat     <= '0;
      ovf_o    <= '0;
      err_id_o <= 1'b0;
    end else begin
      if (state == IDLE && grant_vld) begin
        fmt_id_o <= grant_id;
        rr_ptr   <= (grant_id == ID_W'(NUM_CH - 1)) ? '0 : grant_id + 1'b1;
      end
      if (state == HEAD && fmt_ready_i)      beat <= '0;
      else if (state == BODY && fmt_ready_i) beat <= beat + 1'b1;
      ovf_o <= ovf_o | (push & full & ~pop);
      if (mcdt_val_i && mcdt_id_i == ID_W'(NUM_CH)) err_id_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mcdt_pkt_fmt.sv
// Directed + randomized bench for mcdt_pkt_fmt against a queue-based packet model.
module tb_mcdt_pkt_fmt;

  localparam int DEPTH = 16;
  localparam int PLEN  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mcdt_data;
  logic        mcdt_val;
  logic [1:0]  mcdt_id;
  logic [31:0] fmt_data;
  logic        fmt_valid;
  logic        fmt_ready;
  logic        fmt_start;
  logic        fmt_end;
  logic [1:0]  fmt_id;
  logic [2:0]  ovf;
  logic        err_id;

  always #5 clk = ~clk;

  mcdt_pkt_fmt #(.FIFO_DEPTH(DEPTH), .PKT_LEN(PLEN)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .mcdt_data_i (mcdt_data),
    .mcdt_val_i  (mcdt_val),
    .mcdt_id_i   (mcdt_id),
    .fmt_data_o  (fmt_data),
    .fmt_valid_o (fmt_valid),
    .fmt_ready_i (fmt_ready),
    .fmt_start_o (fmt_start),
    .fmt_end_o   (fmt_end),
    .fmt_id_o    (fmt_id),
    .ovf_o       (ovf),
    .err_id_o    (err_id)
  );

  typedef struct {
    logic [31:0] d;
    logic        s;
    logic        e;
    logic [1:0]  id;
    int          cyc;
  } beat_t;

  beat_t       obs[$];
  beat_t       exp_q[$];
  beat_t       hb;
  logic [31:0] mq [3][$];
  int          rr_m, pend_id;
  bit          pend_v, held;
  logic [2:0]  ovf_m;
  logic        err_m;
  int          vectors = 0, miscompares = 0, cyc = 0, stab_err = 0, chk = 0;

  // Monitor: sampled mid-cycle, so a recorded beat is the one accepted at the next edge.
  always @(negedge clk) begin
    #2;
    cyc++;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && !(fmt_valid && fmt_data === hb.d && fmt_start === hb.s &&
                    fmt_end === hb.e && fmt_id === hb.id))
        stab_err++;
      if (fmt_valid && fmt_ready)
        obs.push_back('{fmt_data, fmt_start, fmt_end, fmt_id, cyc});
      held = fmt_valid && !fmt_ready;
      hb   = '{fmt_data, fmt_start, fmt_end, fmt_id, cyc};
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic void try_grant();
    for (int k = 0; k < 3; k++) begin
      int c;
      c = (rr_m + k) % 3;
      if (!pend_v && mq[c].size() >= PLEN) begin
        pend_v  = 1'b1;
        pend_id = c;
        rr_m    = (c + 1) % 3;
      end
    end
  endfunction

  function automatic void m_clear();
    for (int c = 0; c < 3; c++) mq[c].delete();
    rr_m = 0; pend_v = 1'b0; pend_id = 0; ovf_m = '0; err_m = 1'b0;
  endfunction

  function automatic void m_push(input int ch, input logic [31:0] d);
    if (ch == 3)                     err_m = 1'b1;
    else if (mq[ch].size() >= DEPTH) ovf_m[ch] = 1'b1;
    else                             mq[ch].push_back(d);
    if (!pend_v) try_grant();
  endfunction

  function automatic void m_drain();
    while (pend_v) begin
      exp_q.push_back('{{8'hA5, 6'b0, 2'(pend_id), 8'h00, 8'(PLEN)}, 1'b1, 1'b0, 2'(pend_id), 0});
      for (int b = 0; b < PLEN; b++)
        exp_q.push_back('{mq[pend_id].pop_front(), 1'b0, (b == PLEN - 1), 2'(pend_id), 0});
      pend_v = 1'b0;
      try_grant();
    end
  endfunction

  task automatic drive(input int ch, input logic [31:0] d);
    @(negedge clk);
    mcdt_val  = 1'b1;
    mcdt_id   = 2'(ch);
    mcdt_data = d;
    m_push(ch, d);
  endtask

  task automatic idle_in();
    @(negedge clk);
    mcdt_val = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mcdt_val = 1'b0;
    m_clear();
    @(negedge clk);
    rst = 1'b0;
    obs.delete();
    exp_q.delete();
    chk = 0;
  endtask

  task automatic check_flags(input string tag);
    check({tag, " ovf"}, 64'(ovf), 64'(ovf_m));
    check({tag, " err"}, 64'(err_id), 64'(err_m));
  endtask

  // mode 0: ready high, 1: ready toggles each cycle, 2: random ready.
  task automatic compare(input int mode, input bit gap, input string tag);
    int n = 0;
    while (obs.size() < exp_q.size() && n < 2000) begin
      @(negedge clk);
      case (mode)
        0:       fmt_ready = 1'b1;
        1:       fmt_ready = ~fmt_ready;
        default: fmt_ready = 1'($urandom_range(0, 1));
      endcase
      n++;
    end
    @(negedge clk);
    fmt_ready = 1'b1;
    repeat (8) @(negedge clk);
    check({tag, " count"}, 64'(obs.size()), 64'(exp_q.size()));
    for (int i = chk; i < exp_q.size() && i < obs.size(); i++) begin
      check($sformatf("%s beat %0d", tag, i),
            64'({obs[i].s, obs[i].e, obs[i].id, obs[i].d}),
            64'({exp_q[i].s, exp_q[i].e, exp_q[i].id, exp_q[i].d}));
      if (gap && i > chk && obs[i].s && obs[i-1].e)
        check($sformatf("%s gap %0d", tag, i), 64'(obs[i].cyc - obs[i-1].cyc), 64'd2);
    end
    check({tag, " stable"}, 64'(stab_err), 64'd0);
    chk = exp_q.size();
  endtask

  initial begin
    int n, nb, ch;
    rst = 1'b1; mcdt_val = 1'b0; mcdt_id = '0; mcdt_data = '0; fmt_ready = 1'b0;
    m_clear();
    repeat (3) @(negedge clk);
    #1;
    check("reset outs", 64'({fmt_valid, fmt_start, fmt_end, fmt_id, ovf, err_id, fmt_data}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: single ch0 packet and header latency
    fmt_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive(0, 32'h00C0_0000 + 32'(i));
    @(negedge clk);
    mcdt_val = 1'b0;
    #1 check("t1 no valid at E0", 64'(fmt_valid), 64'd0);
    @(negedge clk);
    #1 check("t1 header at E1", 64'({fmt_valid, fmt_start, fmt_id, fmt_data}), 64'({1'b1, 1'b1, 2'd0, 32'hA500_0004}));
    m_drain();
    compare(0, 1'b0, "t1");

    // 2: three channels fill together, then refill
    do_reset();
    fmt_ready = 1'b0;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 3; c++) drive(c, $urandom);
    idle_in();
    m_drain();
    compare(0, 1'b1, "t2");
    fmt_ready = 1'b0;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 3; c++) drive(c, $urandom);
    idle_in();
    m_drain();
    compare(0, 1'b1, "t2b");

    // 3: toggling ready on a ch1 packet
    fmt_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(1, $urandom);
    idle_in();
    repeat (3) @(negedge clk);
    nb = obs.size();
    m_drain();
    compare(1, 1'b0, "t3");
    check("t3 beats", 64'(obs.size() - nb), 64'd5);

    // 4: overflow of ch2 with ready held low
    do_reset();
    fmt_ready = 1'b0;
    for (int i = 0; i < 17; i++) drive(2, 32'h00C2_0000 + 32'(i));
    idle_in();
    #1 check("t4 ovf", 64'(ovf), 64'b100);
    m_drain();
    compare(0, 1'b1, "t4");
    check_flags("t4");

    // 5: illegal id
    drive(3, 32'h0000_DEAD);
    idle_in();
    #1 check("t5 err", 64'(err_id), 64'd1);
    repeat (5) @(negedge clk);
    #1 check("t5 no valid", 64'(fmt_valid), 64'd0);
    compare(0, 1'b0, "t5 none");
    for (int i = 0; i < 4; i++) drive(0, $urandom);
    idle_in();
    m_drain();
    compare(0, 1'b0, "t5 pkt");

    // randomized rounds
    do_reset();
    for (int r = 0; r < 4; r++) begin
      fmt_ready = 1'b0;
      n = $urandom_range(4, 20);
      for (int j = 0; j < n; j++) begin
        ch = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
        drive(ch, $urandom);
      end
      idle_in();
      m_drain();
      compare(2, 1'b0, $sformatf("rnd%0d", r));
      check_flags($sformatf("rnd%0d", r));
    end

    // 6: reset during a packet
    fmt_ready = 1'b1;
    drive(3, 32'h1234_5678);
    for (int i = 0; i < 4; i++) drive(1, $urandom);
    idle_in();
    m_drain();
    n = 0;
    while (obs.size() < chk + 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6 reach beat2", 64'(n < 100), 64'd1);
    rst = 1'b1;
    #1 check("t6 async clear", 64'({fmt_valid, ovf, err_id, fmt_id}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_clear();
    obs.delete();
    exp_q.delete();
    chk = 0;
    for (int i = 0; i < 4; i++) drive(0, $urandom);
    idle_in();
    m_drain();
    compare(0, 1'b0, "t6 clean");
    check_flags("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
